alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_core.sv | 47 ++++
 rtl/alu.sv | 56 +++++
 tb/tb_alu.sv | 132 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code enum used by the datapath and the control unit.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_MUL = 3'd3,
    ALU_SUB = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, zero flag and signed-overflow flag.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             zero_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] sum, diff, prod;
  logic             sa, sb;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;
  assign prod = a_i * b_i;
  assign sa   = a_i[WIDTH-1];
  assign sb   = b_i[WIDTH-1];

  always_comb begin
    res_o = '0;
    ovf_o = 1'b0;
    case (op_i)
      ALU_AND: res_o = a_i & b_i;
      ALU_OR:  res_o = a_i | b_i;
      ALU_ADD: begin
        res_o = sum;
        ovf_o = (sa == sb) && (sum[WIDTH-1] != sa);
      end
      ALU_MUL: res_o = prod;
      ALU_SUB: begin
        res_o = diff;
        ovf_o = (sa != sb) && (diff[WIDTH-1] != sa);
      end
      // Signed compare directly rather than the sign of diff, so overflow cannot corrupt it.
      ALU_SLT: res_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: res_o = '0;
    endcase
  end

  assign zero_o = (res_o == '0);

endmodule

// File: rtl/alu.sv
// ALU top: combinational core plus one-cycle registered copies of its outputs.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [2:0]       ALUCtrl_i,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o,
  output logic             Ovf_o,
  output logic [WIDTH-1:0] data_q_o,
  output logic             Zero_q_o,
  output logic             Ovf_q_o
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             zero_d, zero_q;
  logic             ovf_d,  ovf_q;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i    (data1_i),
    .b_i    (data2_i),
    .op_i   (ALUCtrl_i),
    .res_o  (data_o),
    .zero_o (Zero_o),
    .ovf_o  (Ovf_o)
  );

  always_comb begin
    data_d = data_o;
    zero_d = Zero_o;
    ovf_d  = Ovf_o;
  end

  // Reset value mirrors a zero result: Zero flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      zero_q <= 1'b1;
      ovf_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign data_q_o = data_q;
  assign Zero_q_o = zero_q;
  assign Ovf_q_o  = ovf_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: combinational results, flags and registered copies.
module tb_alu;
  import alu_pkg::*;

  logic        clk, rst;
  logic [31:0] data1_i, data2_i;
  logic [2:0]  ALUCtrl_i;
  logic [31:0] data_o, data_q_o;
  logic        Zero_o, Ovf_o, Zero_q_o, Ovf_q_o;
  int          n_cmp, n_err;

  alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .ALUCtrl_i (ALUCtrl_i),
    .data_o    (data_o),
    .Zero_o    (Zero_o),
    .Ovf_o     (Ovf_o),
    .data_q_o  (data_q_o),
    .Zero_q_o  (Zero_q_o),
    .Ovf_q_o   (Ovf_q_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
  endtask

  task automatic comb(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] d, input logic z, input logic o);
    drive(op, a, b);
    #1;
    chk({tag, ".d"}, data_o, d);
    chk({tag, ".z"}, {31'd0, Zero_o}, {31'd0, z});
    chk({tag, ".o"}, {31'd0, Ovf_o}, {31'd0, o});
  endtask

  task automatic regchk(input string tag, input logic [31:0] d, input logic z, input logic o);
    chk({tag, ".dq"}, data_q_o, d);
    chk({tag, ".zq"}, {31'd0, Zero_q_o}, {31'd0, z});
    chk({tag, ".oq"}, {31'd0, Ovf_q_o}, {31'd0, o});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(ALU_ADD, 32'd20, 32'd3);

    // Reset held for two edges; combinational path must stay live.
    repeat (2) @(posedge clk);
    #1;
    regchk("rst_hold", 32'd0, 1'b1, 1'b0);
    chk("rst_comb", data_o, 32'd23);

    // Release with Add 20+3: captured at the next edge.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    regchk("rel_add", 32'd23, 1'b0, 1'b0);

    // Op sweep, A=20 B=3.
    @(negedge clk);
    comb("add",  ALU_ADD, 32'd20, 32'd3, 32'd23, 1'b0, 1'b0);
    comb("sub",  ALU_SUB, 32'd20, 32'd3, 32'd17, 1'b0, 1'b0);
    comb("and",  ALU_AND, 32'd20, 32'd3, 32'd0,  1'b1, 1'b0);
    comb("or",   ALU_OR,  32'd20, 32'd3, 32'd23, 1'b0, 1'b0);
    comb("mul",  ALU_MUL, 32'd20, 32'd3, 32'd60, 1'b0, 1'b0);
    comb("slt",  ALU_SLT, 32'd20, 32'd3, 32'd0,  1'b1, 1'b0);

    // Overflow and signed-compare corners.
    comb("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
    comb("sub_ovf", ALU_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    comb("slt_min", ALU_SLT, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b0);
    comb("slt_rev", ALU_SLT, 32'd1, 32'h8000_0000, 32'd0, 1'b1, 1'b0);
    comb("sub_nov", ALU_SUB, 32'd3, 32'd20, 32'hFFFF_FFEF, 1'b0, 1'b0);
    comb("slt_m1",  ALU_SLT, 32'hFFFF_FFFF, 32'd5, 32'd1, 1'b0, 1'b0);
    comb("mul_m1",  ALU_MUL, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB, 1'b0, 1'b0);
    comb("add_m1",  ALU_ADD, 32'hFFFF_FFFF, 32'd5, 32'd4, 1'b0, 1'b0);
    comb("add_nn",  ALU_ADD, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1, 1'b1);

    // Unused codes yield zero.
    comb("op4", 3'd4, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
    comb("op5", 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);

    // Stream into registers, then a one-edge reset mid-stream.
    @(negedge clk);
    drive(ALU_SUB, 32'h8000_0000, 32'd1);
    @(posedge clk);
    #1;
    regchk("strm_sub", 32'h7FFF_FFFF, 1'b0, 1'b1);

    @(negedge clk);
    drive(ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    regchk("mid_rst", 32'd0, 1'b1, 1'b0);
    chk("mid_rst_comb", data_o, 32'h8000_0000);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    regchk("resume", 32'h8000_0000, 1'b0, 1'b1);

    @(negedge clk);
    drive(ALU_MUL, 32'd20, 32'd3);
    @(posedge clk);
    #1;
    regchk("strm_mul", 32'd60, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
